mips_dmem_pipe: RTL and testbench
=================================

Name: mips_dmem_pipe

Overview:
Second-generation MIPS data memory with a parametrised word-organised array, byte-lane writes and a 1-cycle registered read. It adds what the first generation lacked: a valid/ready request handshake, misaligned-access detection, a multi-cycle hardware clear sweep and a saturating fault counter. It sits in the MEM stage, fed by the ALU address and the store data from the pipeline register.

Parameters:
ADDR_SIZE, 10, byte-address bits used. Depth is 2**(ADDR_SIZE-2) 32-bit words. Range 4..16.
CNT_W, 8, width of the misaligned-access counter.

Ports:
clk  input  1  clock; all state changes on rising edge
CLR  input  1  synchronous active-high reset; starts the clear sweep
req_valid  input  1  request present this cycle
req_ready  output  1  block accepts a request this cycle
addr  input  32  byte address; bits above ADDR_SIZE-1 ignored (wrap)
data_in  input  32  store data, right-justified
MemWrite  input  1  1 = store, 0 = load
Byte  input  1  byte access (Half ignored when Byte=1)
Half  input  1  halfword access when Byte=0
UnsignedExt_Mem  input  1  1 = zero-extend load, 0 = sign-extend
rsp_valid  output  1  one-cycle response pulse
data_out  output  32  load result, valid with rsp_valid
misalign  output  1  response flags an alignment fault
busy  output  1  clear sweep in progress
misalign_cnt  output  CNT_W  saturating count of faulting requests

Behaviour:
- Reset: CLR=1 at an edge sets state CLEAR and sweep index to 0. It also sets rsp_valid=0, data_out=0, misalign=0, misalign_cnt=0, req_ready=0 and busy=1. Any request in that cycle is dropped.
- CLEAR: writes one zero word per cycle at the sweep index, then increments the index. After writing the last word the state becomes RUN on the next edge. The full sweep takes 2**(ADDR_SIZE-2) cycles after CLR deasserts.
- CLR asserted mid-sweep restarts the sweep at index 0.
- busy=1 and req_ready=0 throughout CLEAR. req_ready=1 and busy=0 throughout RUN.
- Accept: a request is accepted when req_valid & req_ready at an edge. There is no response backpressure. Back-to-back requests are accepted every cycle.
- Size: {Byte,Half} = 1x selects byte, 01 selects half, 00 selects word.
- Little-endian lanes: byte k = addr[1:0] occupies word bits 8k+7:8k. A halfword at addr[1]=h occupies bits 16h+15:16h.
- Alignment: a half requires addr[0]=0 and a word requires addr[1:0]=00. No silent rounding.
- Misaligned request:
  - no array write;
  - next cycle rsp_valid=1, misalign=1, data_out=0;
  - misalign_cnt increments and saturates at 2**CNT_W-1.
- Aligned store:
  - only the addressed byte lanes are written at the accept edge; other lanes are unchanged;
  - next cycle rsp_valid=1, misalign=0, data_out=0.
- Aligned load:
  - the lane is selected and extended per UnsignedExt_Mem;
  - the result is registered: rsp_valid=1 with data_out in cycle N+1 for acceptance at edge N;
  - a word load ignores UnsignedExt_Mem.
- Read-after-write: a load accepted the cycle after a store to the same word returns the new data. The write commits at the store's accept edge.
- rsp_valid, misalign and data_out hold their response for exactly one cycle. With no acceptance, rsp_valid=0 and data_out=0.
- CLR takes priority over everything, including a pending response. The response pulse is suppressed.

Test Plan:
1. Assert CLR for 1 cycle at ADDR_SIZE=4 -> busy=1 for exactly 4 cycles, req_ready rises on the 5th. Loading word 0x0/0x4/0x8/0xC returns 0x00000000.
2. Store word 0x8000_00FF at 0x4, then load byte at 0x4 with sign extension, then zero extension -> 0xFFFFFFFF, then 0x000000FF. Load byte at 0x7 sign-extended -> 0xFFFFFF80.
3. Store word 0x11223344 at 0x0, store half 0xABCD at 0x2, load word at 0x0 -> 0xABCD3344. rsp_valid is seen one cycle after each accept.
4. Load half at 0x1, store word at 0x6 -> misalign=1 and data_out=0 on each. misalign_cnt goes 0→1→2. A word load at 0x4 is unchanged by the faulting store.
5. Issue 300 misaligned requests with CNT_W=8 -> misalign_cnt saturates at 255.
6. Assert CLR mid-sweep at index 2, and separately while a load is in flight -> sweep restarts at 0, the pending rsp_valid is suppressed, and all outputs are at reset values.

Source files
------------

// File: rtl/mips_dmem_pipe.sv
// rtl/mips_dmem_pipe.sv - MEM-stage data memory with handshake, clear sweep and alignment checks
module mips_dmem_pipe #(
    parameter int ADDR_SIZE = 10,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             CLR,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      addr,
    input  logic [31:0]      data_in,
    input  logic             MemWrite,
    input  logic             Byte,
    input  logic             Half,
    input  logic             UnsignedExt_Mem,
    output logic             rsp_valid,
    output logic [31:0]      data_out,
    output logic             misalign,
    output logic             busy,
    output logic [CNT_W-1:0] misalign_cnt
);

    localparam int WAW   = ADDR_SIZE - 2;
    localparam int DEPTH = 1 << WAW;

    typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [WAW-1:0]     idx_q, idx_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [31:0]        data_out_q, data_out_d;
    logic               misalign_q, misalign_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [31:0]        mem_q [DEPTH];
    logic               mem_we;
    logic [3:0]         mem_be;
    logic [31:0]        mem_wdata;
    logic [WAW-1:0]     mem_widx;

    logic               accept;
    logic [WAW-1:0]     word_idx;
    logic               is_byte, is_half, is_word, bad_align;
    logic [31:0]        rd_word;
    logic [7:0]         rd_byte;
    logic [15:0]        rd_half;
    logic               unused_addr;

    // High address bits wrap by design and are deliberately ignored
    assign unused_addr = ^addr[31:ADDR_SIZE];

    assign accept    = req_valid & req_ready;
    assign word_idx  = addr[ADDR_SIZE-1:2];
    assign is_byte   = Byte;
    assign is_half   = ~Byte & Half;
    assign is_word   = ~Byte & ~Half;
    assign bad_align = (is_half & addr[0]) | (is_word & (addr[1:0] != 2'b00));
    assign rd_word   = mem_q[word_idx];
    assign rd_byte   = rd_word[8*addr[1:0] +: 8];
    assign rd_half   = rd_word[16*addr[1] +: 16];

    // State register; CLR forces a fresh sweep from index 0
    always_ff @(posedge clk) begin
        if (CLR) state_q <= ST_CLEAR;
        else     state_q <= state_d;
    end

    // Next state: leave CLEAR once the last word has been zeroed
    always_comb begin
        state_d = state_q;
        if (state_q == ST_CLEAR && idx_q == {WAW{1'b1}}) state_d = ST_RUN;
    end

    // FSM outputs: handshake ready only while running
    always_comb begin
        req_ready = (state_q == ST_RUN);
        busy      = (state_q == ST_CLEAR);
    end

    // Datapath next values: sweep writes, store lanes, load extension, fault counting
    always_comb begin
        idx_d       = idx_q;
        rsp_valid_d = 1'b0;
        data_out_d  = 32'h0;
        misalign_d  = 1'b0;
        cnt_d       = cnt_q;
        mem_we      = 1'b0;
        mem_be      = 4'h0;
        mem_wdata   = 32'h0;
        mem_widx    = word_idx;
        if (state_q == ST_CLEAR) begin
            mem_we   = ~CLR;
            mem_be   = 4'hF;
            mem_widx = idx_q;
            idx_d    = idx_q + 1'b1;
        end else if (accept) begin
            rsp_valid_d = 1'b1;
            if (bad_align) begin
                misalign_d = 1'b1;
                if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
            end else if (MemWrite) begin
                mem_we = ~CLR;
                if (is_byte) begin
                    mem_be    = 4'b0001 << addr[1:0];
                    mem_wdata = {4{data_in[7:0]}};
                end else if (is_half) begin
                    mem_be    = addr[1] ? 4'b1100 : 4'b0011;
                    mem_wdata = {2{data_in[15:0]}};
                end else begin
                    mem_be    = 4'hF;
                    mem_wdata = data_in;
                end
            end else begin
                if (is_byte)      data_out_d = {{24{~UnsignedExt_Mem & rd_byte[7]}}, rd_byte};
                else if (is_half) data_out_d = {{16{~UnsignedExt_Mem & rd_half[15]}}, rd_half};
                else              data_out_d = rd_word;
            end
        end
    end

    // Datapath registers; CLR clears the response and restarts the sweep index
    always_ff @(posedge clk) begin
        if (CLR) begin
            idx_q       <= '0;
            rsp_valid_q <= 1'b0;
            data_out_q  <= 32'h0;
            misalign_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            idx_q       <= idx_d;
            rsp_valid_q <= rsp_valid_d;
            data_out_q  <= data_out_d;
            misalign_q  <= misalign_d;
            cnt_q       <= cnt_d;
        end
    end

    // Word array with per-lane write enables; contents are not reset, the sweep clears them
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_we && mem_be[b]) mem_q[mem_widx][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    assign rsp_valid    = rsp_valid_q;
    assign data_out     = data_out_q;
    assign misalign     = misalign_q;
    assign misalign_cnt = cnt_q;

endmodule

// File: tb/tb_mips_dmem_pipe.sv
// tb/tb_mips_dmem_pipe.sv - directed self-checking bench for mips_dmem_pipe
`timescale 1ns/1ps
module tb_mips_dmem_pipe;

    logic        clk = 1'b0;
    logic        CLR = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] addr = 32'h0;
    logic [31:0] data_in = 32'h0;
    logic        MemWrite = 1'b0;
    logic        Byte = 1'b0;
    logic        Half = 1'b0;
    logic        UnsignedExt_Mem = 1'b0;
    logic        rsp_valid;
    logic [31:0] data_out;
    logic        misalign;
    logic        busy;
    logic [7:0]  misalign_cnt;

    int tests = 0;
    int fails = 0;

    mips_dmem_pipe #(.ADDR_SIZE(4), .CNT_W(8)) dut (
        .clk(clk), .CLR(CLR), .req_valid(req_valid), .req_ready(req_ready),
        .addr(addr), .data_in(data_in), .MemWrite(MemWrite), .Byte(Byte),
        .Half(Half), .UnsignedExt_Mem(UnsignedExt_Mem), .rsp_valid(rsp_valid),
        .data_out(data_out), .misalign(misalign), .busy(busy),
        .misalign_cnt(misalign_cnt)
    );

    always #5 clk = ~clk;

    // Present one request at the falling edge, return 1ns after the accepting edge
    task automatic req(input logic we, input logic b, input logic h, input logic u,
                       input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        req_valid = 1'b1; MemWrite = we; Byte = b; Half = h; UnsignedExt_Mem = u;
        addr = a; data_in = d;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    // Count edges after CLR release until ready; expected full sweep of 4 words
    task automatic sweep_wait(input string name);
        int n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        tests++;
        if (n !== 4 || busy !== 1'b0) begin
            fails++;
            $display("FAIL %s: busy cycles after release=%0d busy=%b, required 4 and busy=0", name, n, busy);
        end
    endtask

    task automatic test_reset();
        @(negedge clk); CLR = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (busy !== 1'b1 || req_ready !== 1'b0 || rsp_valid !== 1'b0 || data_out !== 32'h0 ||
            misalign !== 1'b0 || misalign_cnt !== 8'h0) begin
            fails++;
            $display("FAIL reset_state: busy=%b ready=%b rv=%b do=%h mis=%b cnt=%0d, required 1 0 0 0 0 0",
                     busy, req_ready, rsp_valid, data_out, misalign, misalign_cnt);
        end
        @(negedge clk); CLR = 1'b0;
        sweep_wait("sweep_len");
        for (int i = 0; i < 4; i++) begin
            req(1'b0, 1'b0, 1'b0, 1'b0, 32'(i * 4), 32'h0);
            tests++;
            if (rsp_valid !== 1'b1 || data_out !== 32'h0) begin
                fails++;
                $display("FAIL cleared_word%0d: rv=%b do=%h, required 1 00000000", i, rsp_valid, data_out);
            end
        end
    endtask

    task automatic test_byte_ext();
        req(1'b1, 1'b0, 1'b0, 1'b0, 32'h4, 32'h8000_00FF);
        tests++;
        if (rsp_valid !== 1'b1 || data_out !== 32'h0 || misalign !== 1'b0) begin
            fails++;
            $display("FAIL store_rsp: rv=%b do=%h mis=%b, required 1 0 0", rsp_valid, data_out, misalign);
        end
        req(1'b0, 1'b1, 1'b0, 1'b0, 32'h4, 32'h0);
        tests++;
        if (data_out !== 32'hFFFF_FFFF) begin
            fails++;
            $display("FAIL lb_signed: got %h, required ffffffff", data_out);
        end
        req(1'b0, 1'b1, 1'b0, 1'b1, 32'h4, 32'h0);
        tests++;
        if (data_out !== 32'h0000_00FF) begin
            fails++;
            $display("FAIL lbu: got %h, required 000000ff", data_out);
        end
        req(1'b0, 1'b1, 1'b0, 1'b0, 32'h7, 32'h0);
        tests++;
        if (data_out !== 32'hFFFF_FF80) begin
            fails++;
            $display("FAIL lb_lane3: got %h, required ffffff80", data_out);
        end
    endtask

    task automatic test_back_to_back();
        req(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h1122_3344);
        tests++;
        if (rsp_valid !== 1'b1) begin
            fails++;
            $display("FAIL b2b_rsp0: rv=%b, required 1", rsp_valid);
        end
        req(1'b1, 1'b0, 1'b1, 1'b0, 32'h2, 32'h0000_ABCD);
        tests++;
        if (rsp_valid !== 1'b1) begin
            fails++;
            $display("FAIL b2b_rsp1: rv=%b, required 1", rsp_valid);
        end
        req(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        tests++;
        if (rsp_valid !== 1'b1 || data_out !== 32'hABCD_3344) begin
            fails++;
            $display("FAIL raw_word: rv=%b do=%h, required 1 abcd3344", rsp_valid, data_out);
        end
        req(1'b0, 1'b0, 1'b1, 1'b0, 32'h2, 32'h0);
        tests++;
        if (data_out !== 32'hFFFF_ABCD) begin
            fails++;
            $display("FAIL lh_signed: got %h, required ffffabcd", data_out);
        end
        idle();
        tests++;
        if (rsp_valid !== 1'b0 || data_out !== 32'h0) begin
            fails++;
            $display("FAIL idle_rsp: rv=%b do=%h, required 0 00000000", rsp_valid, data_out);
        end
    endtask

    task automatic test_misalign();
        req(1'b0, 1'b0, 1'b1, 1'b0, 32'h1, 32'h0);
        tests++;
        if (rsp_valid !== 1'b1 || misalign !== 1'b1 || data_out !== 32'h0 || misalign_cnt !== 8'd1) begin
            fails++;
            $display("FAIL mis_lh: rv=%b mis=%b do=%h cnt=%0d, required 1 1 0 1",
                     rsp_valid, misalign, data_out, misalign_cnt);
        end
        req(1'b1, 1'b0, 1'b0, 1'b0, 32'h6, 32'hDEAD_BEEF);
        tests++;
        if (rsp_valid !== 1'b1 || misalign !== 1'b1 || data_out !== 32'h0 || misalign_cnt !== 8'd2) begin
            fails++;
            $display("FAIL mis_sw: rv=%b mis=%b do=%h cnt=%0d, required 1 1 0 2",
                     rsp_valid, misalign, data_out, misalign_cnt);
        end
        req(1'b0, 1'b0, 1'b0, 1'b0, 32'h4, 32'h0);
        tests++;
        if (misalign !== 1'b0 || data_out !== 32'h8000_00FF) begin
            fails++;
            $display("FAIL mis_nowrite: mis=%b do=%h, required 0 800000ff", misalign, data_out);
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 300; i++) req(1'b0, 1'b0, 1'b0, 1'b0, 32'h1, 32'h0);
        tests++;
        if (misalign_cnt !== 8'd255) begin
            fails++;
            $display("FAIL cnt_sat: got %0d, required 255", misalign_cnt);
        end
    endtask

    task automatic test_clr_midsweep();
        @(negedge clk); CLR = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); CLR = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk); CLR = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); CLR = 1'b0;
        sweep_wait("sweep_restart");
        req(1'b0, 1'b0, 1'b0, 1'b0, 32'h4, 32'h0);
        tests++;
        if (data_out !== 32'h0) begin
            fails++;
            $display("FAIL cleared_after_restart: got %h, required 00000000", data_out);
        end
        req(1'b1, 1'b0, 1'b0, 1'b0, 32'h8, 32'hDEAD_BEEF);
        req(1'b0, 1'b0, 1'b0, 1'b0, 32'h8, 32'h0);
        tests++;
        if (rsp_valid !== 1'b1 || data_out !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL load_before_clr: rv=%b do=%h, required 1 deadbeef", rsp_valid, data_out);
        end
        @(negedge clk); CLR = 1'b1;
        req_valid = 1'b1; MemWrite = 1'b0; Byte = 1'b0; Half = 1'b0; addr = 32'h8;
        @(posedge clk); #1;
        tests++;
        if (rsp_valid !== 1'b0 || data_out !== 32'h0 || misalign !== 1'b0 ||
            misalign_cnt !== 8'h0 || busy !== 1'b1 || req_ready !== 1'b0) begin
            fails++;
            $display("FAIL clr_inflight: rv=%b do=%h mis=%b cnt=%0d busy=%b ready=%b, required 0 0 0 0 1 0",
                     rsp_valid, data_out, misalign, misalign_cnt, busy, req_ready);
        end
        @(negedge clk); CLR = 1'b0; req_valid = 1'b0;
        sweep_wait("sweep_after_inflight");
        req(1'b0, 1'b0, 1'b0, 1'b0, 32'h8, 32'h0);
        tests++;
        if (data_out !== 32'h0) begin
            fails++;
            $display("FAIL cleared_after_inflight: got %h, required 00000000", data_out);
        end
    endtask

    initial begin
        test_reset();
        test_byte_ext();
        test_back_to_back();
        test_misalign();
        test_saturate();
        test_clr_midsweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
